// File: rtl/z80_pkg.sv
// Shared Z80 definitions: register-file command codes, flag bit positions and
// the block-transfer sequencer state encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
package z80_pkg;

  // Register file special-command port codes.
  localparam logic [2:0] CMD_NOPE = 3'd0;
  localparam logic [2:0] CMD_INC  = 3'd1;
  localparam logic [2:0] CMD_DEC  = 3'd2;

  // Flag register bit positions.
  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_H  = 4;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_UPD,
    ST_DONE
  } blk_state_t;

  // ED A0/A8/B0/B8/A1/A9/B1/B9: bits 7..5 = 101, bits 2..1 = 00.
  // bit0 = compare group, bit3 = decrement, bit4 = repeat.
  function automatic logic blk_op_valid(input logic [7:0] op);
    return (op & 8'hE6) == 8'hA0;
  endfunction

endpackage

// File: rtl/block_xfer_ctl_if.sv
// Memory bus between the block-transfer sequencer (master) and memory (slave).
// Latency: n/a. Backpressure: request and address/data hold until mem_ack.
// Signals: mem_req/mem_we/mem_addr/mem_o from master, mem_i/mem_ack from slave.
interface block_xfer_ctl_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_o;
  logic [7:0]  mem_i;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_o,
    input  mem_i, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_o,
    output mem_i, mem_ack
  );
endinterface

// File: rtl/blk_flags.sv
// Flag and repeat computation for one block-op iteration (purely combinational).
// Latency: 0 cycles. Backpressure: none.
// Ports: a, data, f, bc_n, is_cp, is_rep in; flag, rep out.
module blk_flags
  import z80_pkg::*;
(
  input  logic [7:0]  a,
  input  logic [7:0]  data,
  input  logic [7:0]  f,
  input  logic [15:0] bc_n,
  input  logic        is_cp,
  input  logic        is_rep,
  output logic [7:0]  flag,
  output logic        rep
);

  logic [7:0] r;
  logic       half_borrow;
  logic       bc_nz;

  assign r           = a - data;
  assign half_borrow = a[3:0] < data[3:0];
  assign bc_nz       = bc_n != 16'd0;

  always_comb begin
    // Start from the old flags so S/Z/5/3/C carry through unless overridden.
    flag          = f;
    flag[FLAG_C]  = f[FLAG_C];
    flag[FLAG_PV] = bc_nz;
    flag[FLAG_H]  = 1'b0;
    flag[FLAG_N]  = 1'b0;
    rep           = is_rep && bc_nz;
    if (is_cp) begin
      flag[FLAG_S] = r[7];
      flag[FLAG_Z] = (r == 8'd0);
      flag[FLAG_H] = half_borrow;
      flag[FLAG_N] = 1'b1;
      rep          = is_rep && bc_nz && (r != 8'd0);
    end
  end

endmodule

// File: rtl/block_xfer_ctl.sv
// Sequencer for Z80 LDI/LDD/LDIR/LDDR/CPI/CPD/CPIR/CPDR: memory cycles, BC/DE/HL step, flags.
// Latency: LDI start->done 5 cycles at zero wait; iteration LD 3 / CP 2 cycles.
// Backpressure: each memory cycle holds req/addr/data until mem_ack; start only taken in IDLE.
// Ports: pin_clk/reset; start/opcode from decoder; bc/de/hl/a/f/int_req live inputs;
// mem bus (master); cmd/flg_w/flag to register file; busy/done/rewind to decoder.
module block_xfer_ctl
  import z80_pkg::*;
(
  input  logic             pin_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       opcode,
  input  logic [15:0]      bc,
  input  logic [15:0]      de,
  input  logic [15:0]      hl,
  input  logic [7:0]       a,
  input  logic [7:0]       f,
  input  logic             int_req,
  block_xfer_ctl_if.master mem,
  output logic [2:0]       cmd,
  output logic             flg_w,
  output logic [7:0]       flag,
  output logic             busy,
  output logic             done,
  output logic             rewind
);

  blk_state_t  state, state_n;
  logic        is_cp, is_dec, is_rep;
  logic [7:0]  data;
  logic [15:0] bc_n;
  logic        rew_q;
  logic        start_ok;
  logic [7:0]  flag_calc;
  logic        rep;

  assign start_ok = start && blk_op_valid(opcode);

  blk_flags u_flags (
    .a      (a),
    .data   (data),
    .f      (f),
    .bc_n   (bc_n),
    .is_cp  (is_cp),
    .is_rep (is_rep),
    .flag   (flag_calc),
    .rep    (rep)
  );

  always_ff @(posedge pin_clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      is_cp  <= 1'b0;
      is_dec <= 1'b0;
      is_rep <= 1'b0;
      data   <= 8'd0;
      bc_n   <= 16'd0;
      rew_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && start_ok) begin
        is_cp  <= opcode[0];
        is_dec <= opcode[3];
        is_rep <= opcode[4];
      end
      if (state == ST_RD && mem.mem_ack) begin
        data <= mem.mem_i;
      end
      // The register file updates BC on the falling edge inside UPD, so the
      // decrement is frozen on entry to UPD rather than taken from live bc.
      if (state != ST_UPD) begin
        bc_n <= bc - 16'd1;
      end
      if (state == ST_UPD) begin
        rew_q <= rep && int_req;
      end
    end
  end

  always_comb begin
    state_n      = state;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_addr = 16'd0;
    mem.mem_o    = 8'd0;
    cmd          = CMD_NOPE;
    flg_w        = 1'b0;
    flag         = 8'd0;
    busy         = (state != ST_IDLE);
    done         = 1'b0;
    rewind       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_n = ST_RD;
      end
      ST_RD: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = hl;
        if (mem.mem_ack) state_n = is_cp ? ST_UPD : ST_WR;
      end
      ST_WR: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_addr = de;
        mem.mem_o    = data;
        if (mem.mem_ack) state_n = ST_UPD;
      end
      ST_UPD: begin
        cmd   = is_dec ? CMD_DEC : CMD_INC;
        flg_w = 1'b1;
        flag  = flag_calc;
        state_n = (rep && !int_req) ? ST_RD : ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        rewind  = rew_q;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_block_xfer_ctl.sv
// Testbench for block_xfer_ctl: memory model with wait states, falling-edge
// register file model, and a scoreboard of expected memory transactions.
module tb_block_xfer_ctl;
  import z80_pkg::*;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  dat;
  } xfer_t;

  logic        pin_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic        int_req = 1'b0;
  logic [7:0]  opcode  = 8'h00;
  logic [7:0]  a       = 8'h00;
  logic [7:0]  f       = 8'h00;
  logic [15:0] bc      = 16'h0000;
  logic [15:0] de      = 16'h0000;
  logic [15:0] hl      = 16'h0000;
  logic [2:0]  cmd;
  logic        flg_w, busy, done, rewind;
  logic [7:0]  flag;

  block_xfer_ctl_if mif ();

  block_xfer_ctl dut (
    .pin_clk (pin_clk),
    .reset   (reset),
    .start   (start),
    .opcode  (opcode),
    .bc      (bc),
    .de      (de),
    .hl      (hl),
    .a       (a),
    .f       (f),
    .int_req (int_req),
    .mem     (mif),
    .cmd     (cmd),
    .flg_w   (flg_w),
    .flag    (flag),
    .busy    (busy),
    .done    (done),
    .rewind  (rewind)
  );

  always #5 pin_clk = ~pin_clk;

  int    tests_run = 0;
  int    fails     = 0;
  xfer_t exp_q[$];

  // Memory model
  logic [7:0] mem [0:65535];
  int  n_wait   = 0;
  int  wait_cnt = 0;
  bit  hold_wr  = 1'b0;

  assign mif.mem_ack = mif.mem_req && !(mif.mem_we && hold_wr) && (wait_cnt >= n_wait);
  assign mif.mem_i   = mem[mif.mem_addr];

  always @(posedge pin_clk) begin
    if (reset || !mif.mem_req || mif.mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Register file model and scoreboard consumer, both on the falling edge.
  bit cur_cp = 1'b0;
  int n_inc = 0, n_dec = 0, n_reads = 0;

  always @(negedge pin_clk) begin
    xfer_t e, g;
    if (!reset) begin
      if (mif.mem_req && mif.mem_ack) begin
        g = '{we: mif.mem_we, addr: mif.mem_addr, dat: (mif.mem_we ? mif.mem_o : mif.mem_i)};
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got we=%b addr=%h dat=%h, required no transaction", g.we, g.addr, g.dat);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            fails++;
            $display("FAIL sb_xfer: got we=%b addr=%h dat=%h, required we=%b addr=%h dat=%h",
                     g.we, g.addr, g.dat, e.we, e.addr, e.dat);
          end
        end
        if (mif.mem_we) mem[mif.mem_addr] = mif.mem_o;
        else n_reads++;
      end
      if (flg_w || cmd != CMD_NOPE) begin
        tests_run++;
        if (!(flg_w && (cmd == CMD_INC || cmd == CMD_DEC) && !mif.mem_req)) begin
          fails++;
          $display("FAIL upd_strobes: cmd=%0d flg_w=%b mem_req=%b, required INC/DEC with flg_w=1 and no mem cycle",
                   cmd, flg_w, mif.mem_req);
        end
      end
      if (cmd == CMD_INC) begin
        hl = hl + 16'd1; if (!cur_cp) de = de + 16'd1; bc = bc - 16'd1; n_inc++;
      end else if (cmd == CMD_DEC) begin
        hl = hl - 16'd1; if (!cur_cp) de = de - 16'd1; bc = bc - 16'd1; n_dec++;
      end
      if (flg_w) f = flag;
    end
  end

  task automatic push_xfer(input logic we, input logic [15:0] ad, input logic [7:0] dt);
    xfer_t x;
    x = '{we: we, addr: ad, dat: dt};
    exp_q.push_back(x);
  endtask

  task automatic setup(input logic [15:0] hl0, input logic [15:0] de0, input logic [15:0] bc0,
                       input logic [7:0] a0, input logic [7:0] f0, input bit cp);
    hl = hl0; de = de0; bc = bc0; a = a0; f = f0; cur_cp = cp;
    n_inc = 0; n_dec = 0; n_reads = 0;
  endtask

  // Issues start at posedge+1 and waits (bounded) for done; returns in IDLE.
  task automatic run_op(input logic [7:0] op, input bit arm_int, input int limit,
                        output int cyc, output logic rew);
    start = 1'b1; opcode = op; cyc = 1;
    do begin
      @(posedge pin_clk); #1;
      start = 1'b0;
      cyc++;
      if (arm_int && mif.mem_req && !mif.mem_we && n_reads == 1) int_req = 1'b1;
    end while (done !== 1'b1 && cyc < limit);
    rew = rewind;
    tests_run++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL op_%h_timeout: done=%b after %0d cycles, required 1", op, done, cyc);
    end
    @(posedge pin_clk); #1;
    int_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge pin_clk);
    #1;
    tests_run++;
    if ({mif.mem_req, mif.mem_we, flg_w, busy, done, rewind} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctl: req/we/flg_w/busy/done/rewind=%b, required 000000",
               {mif.mem_req, mif.mem_we, flg_w, busy, done, rewind});
    end
    tests_run++;
    if (mif.mem_addr !== 16'h0 || mif.mem_o !== 8'h0 || flag !== 8'h0) begin
      fails++;
      $display("FAIL reset_data: addr=%h o=%h flag=%h, required 0000 00 00", mif.mem_addr, mif.mem_o, flag);
    end
    tests_run++;
    if (cmd !== CMD_NOPE) begin
      fails++; $display("FAIL reset_cmd: cmd=%0d, required %0d", cmd, CMD_NOPE);
    end
    reset = 1'b0;
    @(posedge pin_clk); #1;
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: busy=%b, required 0", busy); end
  endtask

  task automatic test_ldi();
    int cyc; logic rew;
    setup(16'h0104, 16'h0002, 16'h0001, 8'h00, 8'hFF, 1'b0);
    mem[16'h0104] = 8'h5A; mem[16'h0002] = 8'h00;
    push_xfer(1'b0, 16'h0104, 8'h5A);
    push_xfer(1'b1, 16'h0002, 8'h5A);
    run_op(8'hA0, 1'b0, 40, cyc, rew);
    tests_run++; if (cyc !== 5) begin fails++; $display("FAIL ldi_cycles: %0d, required 5", cyc); end
    tests_run++; if (n_inc !== 1 || n_dec !== 0) begin fails++; $display("FAIL ldi_cmd: inc=%0d dec=%0d, required 1 0", n_inc, n_dec); end
    tests_run++; if (f !== 8'hE9) begin fails++; $display("FAIL ldi_flags: %h, required e9", f); end
    tests_run++; if (mem[16'h0002] !== 8'h5A) begin fails++; $display("FAIL ldi_mem: %h, required 5a", mem[16'h0002]); end
    tests_run++; if (rew !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL ldi_end: rewind=%b busy=%b, required 0 0", rew, busy); end
  endtask

  task automatic test_ldir();
    int cyc; logic rew;
    setup(16'h2000, 16'h3000, 16'h0003, 8'h00, 8'h14, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mem[16'h2000 + i] = 8'h11 * (i + 1);
      push_xfer(1'b0, 16'h2000 + i[15:0], 8'h11 * (i + 1));
      push_xfer(1'b1, 16'h3000 + i[15:0], 8'h11 * (i + 1));
    end
    run_op(8'hB0, 1'b0, 80, cyc, rew);
    tests_run++; if (cyc !== 11) begin fails++; $display("FAIL ldir_cycles: %0d, required 11", cyc); end
    tests_run++; if (n_inc !== 3) begin fails++; $display("FAIL ldir_inc: %0d, required 3", n_inc); end
    tests_run++; if (f !== 8'h00 || rew !== 1'b0) begin fails++; $display("FAIL ldir_end: f=%h rewind=%b, required 00 0", f, rew); end
    tests_run++; if (bc !== 16'h0 || de !== 16'h3003) begin fails++; $display("FAIL ldir_regs: bc=%h de=%h, required 0000 3003", bc, de); end
  endtask

  task automatic test_cpir();
    int cyc; logic rew;
    logic [7:0] dat [3];
    dat[0] = 8'h00; dat[1] = 8'h11; dat[2] = 8'h42;
    setup(16'h4000, 16'h1234, 16'h0010, 8'h42, 8'h01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      mem[16'h4000 + i] = dat[i];
      push_xfer(1'b0, 16'h4000 + i[15:0], dat[i]);
    end
    mem[16'h4003] = 8'h42;
    run_op(8'hB1, 1'b0, 80, cyc, rew);
    tests_run++; if (cyc !== 8) begin fails++; $display("FAIL cpir_cycles: %0d, required 8", cyc); end
    tests_run++; if (f !== 8'h47) begin fails++; $display("FAIL cpir_flags: %h, required 47", f); end
    tests_run++; if (n_inc !== 3 || bc !== 16'h000D || hl !== 16'h4003) begin
      fails++; $display("FAIL cpir_regs: inc=%0d bc=%h hl=%h, required 3 000d 4003", n_inc, bc, hl);
    end
  endtask

  task automatic test_cpi_flags();
    int cyc; logic rew;
    setup(16'h4100, 16'h0000, 16'h0001, 8'h00, 8'h28, 1'b1);
    mem[16'h4100] = 8'h01;
    push_xfer(1'b0, 16'h4100, 8'h01);
    run_op(8'hA1, 1'b0, 40, cyc, rew);
    tests_run++; if (cyc !== 4) begin fails++; $display("FAIL cpi_cycles: %0d, required 4", cyc); end
    tests_run++; if (f !== 8'hBA) begin fails++; $display("FAIL cpi_flags: %h, required ba", f); end
  endtask

  task automatic test_lddr_int();
    int cyc; logic rew;
    n_wait = 2;
    setup(16'h5005, 16'h6005, 16'h0005, 8'h00, 8'h00, 1'b0);
    mem[16'h5005] = 8'hA5; mem[16'h5004] = 8'h5A;
    push_xfer(1'b0, 16'h5005, 8'hA5); push_xfer(1'b1, 16'h6005, 8'hA5);
    push_xfer(1'b0, 16'h5004, 8'h5A); push_xfer(1'b1, 16'h6004, 8'h5A);
    run_op(8'hB8, 1'b1, 120, cyc, rew);
    n_wait = 0;
    tests_run++; if (cyc !== 16) begin fails++; $display("FAIL lddr_cycles: %0d, required 16", cyc); end
    tests_run++; if (rew !== 1'b1) begin fails++; $display("FAIL lddr_rewind: %b, required 1", rew); end
    tests_run++; if (n_dec !== 2 || n_inc !== 0 || bc !== 16'h0003) begin
      fails++; $display("FAIL lddr_regs: dec=%0d inc=%0d bc=%h, required 2 0 0003", n_dec, n_inc, bc);
    end
    tests_run++; if (f !== 8'h04) begin fails++; $display("FAIL lddr_flags: %h, required 04", f); end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    setup(16'h0200, 16'h0300, 16'h0002, 8'h00, 8'h00, 1'b0);
    mem[16'h0200] = 8'h77; mem[16'h0300] = 8'h00;
    push_xfer(1'b0, 16'h0200, 8'h77);
    hold_wr = 1'b1;
    start = 1'b1; opcode = 8'hA0;
    @(posedge pin_clk); #1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge pin_clk); #1;
      tests_run++;
      if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1 || mif.mem_addr !== 16'h0300 || mif.mem_o !== 8'h77) begin
        fails++;
        $display("FAIL wr_hold: req=%b we=%b addr=%h o=%h, required 1 1 0300 77",
                 mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_o);
      end
    end
    reset = 1'b1;
    @(posedge pin_clk); #1;
    reset = 1'b0; hold_wr = 1'b0;
    tests_run++;
    if (mif.mem_req !== 1'b0 || busy !== 1'b0 || cmd !== CMD_NOPE) begin
      fails++; $display("FAIL rst_mid: req=%b busy=%b cmd=%0d, required 0 0 0", mif.mem_req, busy, cmd);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge pin_clk); #1;
      saw_done |= done;
    end
    tests_run++;
    if (saw_done || n_inc !== 0 || bc !== 16'h0002 || mem[16'h0300] !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_after: done_seen=%b inc=%0d bc=%h mem=%h, required 0 0 0002 00",
               saw_done, n_inc, bc, mem[16'h0300]);
    end
  endtask

  task automatic test_invalid_op();
    int cyc; logic rew; bit saw_busy;
    start = 1'b1; opcode = 8'hB2;
    saw_busy = 1'b0;
    @(posedge pin_clk); #1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      saw_busy |= (busy | mif.mem_req);
      @(posedge pin_clk); #1;
    end
    tests_run++;
    if (saw_busy) begin fails++; $display("FAIL invalid_op: busy/mem_req seen=1, required 0"); end
    setup(16'h0700, 16'h0800, 16'h0004, 8'h00, 8'h00, 1'b0);
    mem[16'h0700] = 8'hC3;
    push_xfer(1'b0, 16'h0700, 8'hC3); push_xfer(1'b1, 16'h0800, 8'hC3);
    run_op(8'hA0, 1'b0, 40, cyc, rew);
    tests_run++; if (cyc !== 5) begin fails++; $display("FAIL after_invalid_cycles: %0d, required 5", cyc); end
    tests_run++; if (mem[16'h0800] !== 8'hC3 || f !== 8'h04) begin
      fails++; $display("FAIL after_invalid: mem=%h f=%h, required c3 04", mem[16'h0800], f);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_ldir();
    test_cpir();
    test_cpi_flags();
    test_lddr_int();
    test_reset_mid();
    test_invalid_op();
    repeat (2) @(posedge pin_clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL sb_leftover: %0d transactions pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/block_xfer_ctl.md
# block_xfer_ctl

Sequencer for the Z80 ED-prefixed block transfer and compare group: LDI, LDD, LDIR, LDDR, CPI, CPD, CPIR and CPDR. It sits between the instruction decoder and the register file, and drives the register file's special-command port (`CMD_INC`/`CMD_DEC`) and flag write. It runs the memory read/write handshakes for each iteration and decides whether to repeat or terminate. The decoder hands over control with `start` and regains it on `done`.

## Interface
Parameters
- none; command codes and flag bit positions come from the shared package.

Ports
- `pin_clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `opcode` in 8: second byte after ED (A0, A8, B0, B8, A1, A9, B1, B9); latched on `start`.
- `bc`, `de`, `hl` in 16: live register file values.
- `a`, `f` in 8: live accumulator and flags.
- `int_req` in 1: interrupt pending; sampled at the repeat decision.
- `mem_req` out 1: memory cycle request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 16: memory address.
- `mem_o` out 8: write data.
- `mem_i` in 8: read data, valid when `mem_ack` = 1.
- `mem_ack` in 1: completes the current memory cycle.
- `cmd` out 3: register file special command (NOPE/INC/DEC).
- `flg_w` out 1: flag write strobe.
- `flag` out 8: new flag value.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `rewind` out 1: valid with `done`; the decoder must subtract 2 from PC so the instruction re-executes after the interrupt.

## Operation
States: IDLE, RD, WR, UPD, DONE.
- **IDLE**
  - On `start` with a valid opcode, latch `opcode` and go to RD.
  - Invalid opcodes are ignored; the block stays in IDLE.
  - `start` in any other state is ignored.
- **RD**
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=`hl`.
  - On `mem_ack`, latch `mem_i` into `data`.
  - Next state is WR for the LD group, UPD for the CP group.
- **WR**
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr`=`de`, `mem_o`=`data`.
  - On `mem_ack`, go to UPD.
- **UPD** (exactly one cycle)
  - `cmd` = INC when opcode bit 3 = 0, DEC when bit 3 = 1.
  - `flg_w` = 1.
  - `bc_n` = `bc` − 1, modulo 2^16.
- **Flags (Z80 positions S7 Z6 H4 PV2 N1 C0)**
  - LD group:
    - S, Z, C keep the value of `f`; H = 0; N = 0; PV = (`bc_n` != 0).
  - CP group:
    - `r` = `a` − `data`, 8-bit.
    - S = `r[7]`; Z = (`r` == 0); H = borrow from bit 4; N = 1; PV = (`bc_n` != 0); C keeps the value of `f`.
  - Bits 5 and 3 keep the value of `f`.
- **Repeat decision** (in UPD)
  - `rep` = opcode bit 4 AND (`bc_n` != 0).
  - For the CP group, `rep` additionally requires `r` != 0.
  - If `rep` and not `int_req`: go to RD.
  - If `rep` and `int_req`: go to DONE with `rewind`=1.
  - Otherwise: go to DONE with `rewind`=0.
- **DONE**
  - Assert `done`=1 for one cycle, then go to IDLE.
- **BC = 0 on entry:** `bc_n` = FFFF, so a repeating op runs 65536 iterations, as on real Z80 hardware.

## Timing
- **Reset values:** state IDLE; `mem_req`, `mem_we`, `flg_w`, `busy`, `done`, `rewind` = 0; `mem_addr`, `mem_o`, `flag` = 0; `cmd` = NOPE.
- **`busy`:** rises the cycle after `start` is accepted and falls in the cycle after DONE.
- **Memory handshake**
  - `mem_req` and the address/data stay stable until `mem_ack` is sampled high.
  - `mem_ack` may arrive in the same cycle `mem_req` is first asserted (zero-wait).
  - `mem_ack` while `mem_req` = 0 is ignored.
- **Register file update:** the register file writes on the falling edge, so `bc`/`de`/`hl` already hold updated values at the rising edge that leaves UPD. The next RD therefore uses the new `hl`.
- **Minimum iteration:** LD = 3 cycles, CP = 2 cycles at zero-wait.
- **Minimum single op:** LDI total from `start` to `done` = 5 cycles.
- **`cmd` and `flg_w`:** both are asserted only in UPD, never in any other state.
- **Reset mid-operation:** any in-flight memory cycle is abandoned; `mem_req` drops in the cycle after the reset edge. No `done` pulse is produced and no register update occurs.
- **`int_req` sampling:** only in UPD; during RD/WR it has no effect.

## Structure
- The shared package `z80_pkg` holds:
  - `CMD_NOPE`/`CMD_INC`/`CMD_DEC` codes, shared with the register file;
  - flag bit indices;
  - state encoding for this block.
- No sub-module is required. The compare/flag logic may optionally be split into `blk_flags`, which is purely combinational (`a`, `data`, `f`, `bc_n`, op class → `flag`, `rep`).

## Test plan
- LDI, `hl`=0104, `de`=0002, `bc`=0001, mem[0104]=5A:
  - read 0104, write 5A to 0002, one UPD cycle with `cmd`=INC;
  - PV=0, `done` at cycle 5.
- LDIR, `bc`=0003, zero-wait memory:
  - 3 iterations at 3 cycles each;
  - `cmd` = INC exactly 3 times; final PV=0; `rewind`=0.
- CPIR, `a`=42, `bc`=0010, data 00,11,42:
  - stops after the 3rd read with Z=1, N=1, PV=1;
  - C unchanged from its entry value.
- LDDR, `bc`=0005, `int_req` raised during the 2nd RD with 2 wait states per access:
  - stops after iteration 2 with `done`=1 and `rewind`=1;
  - `cmd` = DEC twice.
- `reset` asserted during WR with `mem_ack` held low:
  - next cycle `mem_req`=0, `busy`=0, `cmd`=NOPE;
  - no `done` pulse.
- Invalid opcode B2 with `start`:
  - no state change, `busy` stays 0;
  - a following LDI `start` is accepted normally.
